// File: rtl/bus_mux_stom_router.sv
// Registered slave-to-master return-path router: forwards the lanes of one slave to one master,
// with a programmable all-idle guard gap between routes.
module bus_mux_stom_router #(
   parameter int unsigned NO_MASTERS = 3,
   parameter int unsigned NO_SLAVES  = 5,
   parameter int unsigned LANES      = 1,
   parameter int unsigned SWITCH_GAP = 2,
   parameter logic        IDLE_LVL   = 1'b0,
   localparam int unsigned MW = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1,
   localparam int unsigned SW = (NO_SLAVES > 1) ? $clog2(NO_SLAVES) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        route_req,
   input  logic [MW-1:0]               master_sel,
   input  logic [SW-1:0]               slave_sel,
   input  logic                        route_release,
   input  logic [NO_SLAVES*LANES-1:0]  slave,
   output logic [NO_MASTERS*LANES-1:0] master,
   output logic                        route_ack,
   output logic                        route_active,
   output logic                        route_err
);

   localparam logic [3:0] GapLast = (SWITCH_GAP == 0) ? 4'd0 : 4'(SWITCH_GAP - 1);
   localparam logic [NO_MASTERS*LANES-1:0] IdleVec = {(NO_MASTERS*LANES){IDLE_LVL}};

   typedef enum logic [1:0] {StIdle, StGap, StRoute} state_e;

   state_e                      state_q, state_d;
   logic [MW-1:0]               m_lat_q, m_lat_d;
   logic [SW-1:0]               s_lat_q, s_lat_d;
   logic [3:0]                  cnt_q, cnt_d;
   logic [NO_MASTERS*LANES-1:0] master_q, master_d;
   logic                        ack_q, ack_d;
   logic                        err_q, err_d;
   logic                        req_valid;
   logic [LANES-1:0]            sel_lanes;

   assign req_valid = route_req && (32'(master_sel) < NO_MASTERS)
                                && (32'(slave_sel) < NO_SLAVES);

   always_comb begin
      state_d = state_q;
      m_lat_d = m_lat_q;
      s_lat_d = s_lat_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      err_d   = route_req && !req_valid;
      unique case (state_q)
         StIdle, StRoute: begin
            if (req_valid) begin
               m_lat_d = master_sel;
               s_lat_d = slave_sel;
               cnt_d   = 4'd0;
               if (SWITCH_GAP == 0) begin
                  state_d = StRoute;
                  ack_d   = 1'b1;
               end else begin
                  state_d = StGap;
               end
            end else if (route_release) begin
               state_d = StIdle;
            end
         end
         StGap: begin
            if (req_valid) begin
               // A fresh request restarts the full guard interval.
               m_lat_d = master_sel;
               s_lat_d = slave_sel;
               cnt_d   = 4'd0;
            end else if (route_release) begin
               state_d = StIdle;
            end else if (cnt_q == GapLast) begin
               state_d = StRoute;
               ack_d   = 1'b1;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Forwarding keys off the next state so a route is live on the same edge as its ack.
   always_comb begin
      sel_lanes = '0;
      for (int unsigned s = 0; s < NO_SLAVES; s++) begin
         if (s_lat_d == SW'(s)) sel_lanes = slave[s*LANES +: LANES];
      end
      master_d = IdleVec;
      if (state_d == StRoute) begin
         for (int unsigned m = 0; m < NO_MASTERS; m++) begin
            if (m_lat_d == MW'(m)) master_d[m*LANES +: LANES] = sel_lanes;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         m_lat_q  <= '0;
         s_lat_q  <= '0;
         cnt_q    <= 4'd0;
         master_q <= IdleVec;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_lat_q  <= m_lat_d;
         s_lat_q  <= s_lat_d;
         cnt_q    <= cnt_d;
         master_q <= master_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   assign master       = master_q;
   assign route_ack    = ack_q;
   assign route_active = (state_q == StRoute);
   assign route_err    = err_q;

endmodule
